// File: rtl/adder_pkg.sv
// adder_pkg: mode encodings and parameter sanity check shared by the pipelined adder
package adder_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic bit width_ok(int width, int stages);
    return stages > 0 && width % stages == 0;
  endfunction
endpackage

// File: rtl/carry_chunk.sv
// carry_chunk: combinational ripple adder for one CW-bit chunk, exposing the carry into its top bit
module carry_chunk
  import adder_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          msb_cin
);
  logic [CW:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout    = c[CW];
  assign msb_cin = c[CW-1];
endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into STAGES registered carry chunks
// with a valid/ready stream; every stage shifts together whenever the output is free.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;
  logic advance;
  if (!width_ok(WIDTH, STAGES)) begin : g_bad
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES");
  end
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * CW;
    logic [RW-1:0]         a_in, b_in;
    logic                  c_in, v_in, co, mc, v_q, c_q;
    logic [CW-1:0]         s;
    logic [(k+1)*CW-1:0]   r_nx, r_q;
    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = sub == MODE_ADD ? b : ~b;
      assign c_in = sub == MODE_SUB ? 1'b1 : cin;
      assign v_in = in_valid;
      assign r_nx = s;
    end else begin : g_body
      assign a_in = g_st[k-1].g_skew.a_q;
      assign b_in = g_st[k-1].g_skew.b_q;
      assign c_in = g_st[k-1].c_q;
      assign v_in = g_st[k-1].v_q;
      assign r_nx = {s, g_st[k-1].r_q};
    end
    carry_chunk #(.CW(CW)) u_chunk (
      .a       (a_in[CW-1:0]),
      .b       (b_in[CW-1:0]),
      .cin     (c_in),
      .sum     (s),
      .cout    (co),
      .msb_cin (mc)
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= co;
        r_q <= r_nx;
      end
    if (k < STAGES - 1) begin : g_skew
      // operand bits still waiting for their chunk
      logic [RW-CW-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[RW-1:CW];
          b_q <= b_in[RW-1:CW];
        end
    end else begin : g_tail
      logic o_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) o_q <= 1'b0;
        else if (advance) o_q <= co ^ mc;
    end
  end
  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].r_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = g_st[STAGES-1].g_tail.o_q;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed checks of the 32-bit, 4-stage pipelined adder
module tb_pipelined_carry_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  int pass_cnt = 0;
  int total = 0;

  pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // drives one beat into an empty pipe and waits (bounded) for its result
  task automatic run_one(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                         input logic xs, output logic [33:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = xa; b = xb; cin = xc; sub = xs; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {sum, cout, ovf};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1 total++;
      if ({out_valid, sum, cout, ovf} !== 35'd0)
        $display("FAIL reset_hold: got valid=%b sum=%h cout=%b ovf=%b want all 0", out_valid, sum, cout, ovf);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1 total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_cross_chunk();
    logic [33:0] r;
    int lat;
    run_one(32'h000000FF, 32'h00000001, 1'b0, 1'b0, r, lat);
    total++;
    if (lat != 4) $display("FAIL cross_latency: got %0d want 4", lat);
    else pass_cnt++;
    total++;
    if (r !== {32'h00000100, 1'b0, 1'b0}) $display("FAIL cross_sum: got %h want %h", r, {32'h00000100, 2'b00});
    else pass_cnt++;
  endtask

  task automatic test_limits();
    logic [31:0] va [3] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000};
    logic [31:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h00000000};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [33:0] ve [3] = '{{32'h00000000, 2'b10}, {32'h80000000, 2'b01}, {32'h00000001, 2'b00}};
    logic [33:0] r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(va[i], vb[i], vc[i], 1'b0, r, lat);
      total++;
      if (r !== ve[i]) $display("FAIL limit_%0d: got %h want %h", i, r, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_subtract();
    logic [31:0] va [3] = '{32'd5, 32'd7, 32'h80000000};
    logic [31:0] vb [3] = '{32'd7, 32'd5, 32'd1};
    logic        vc [3] = '{1'b1, 1'b0, 1'b0};
    logic [33:0] ve [3] = '{{32'hFFFFFFFE, 2'b00}, {32'h00000002, 2'b10}, {32'h7FFFFFFF, 2'b11}};
    logic [33:0] r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(va[i], vb[i], vc[i], 1'b1, r, lat);
      total++;
      if (r !== ve[i]) $display("FAIL sub_%0d: got %h want %h", i, r, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8] = '{32'd1, 32'd10, 32'hFFFF0000, 32'd100, 32'h40000000, 32'd3, 32'h12345678, 32'h0000FFFF};
    logic [31:0] vb [8] = '{32'd2, 32'd20, 32'h00010000, 32'd1, 32'h40000000, 32'd4, 32'h11111111, 32'h00000001};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [33:0] ve [8] = '{{32'h00000003, 2'b00}, {32'h0000001F, 2'b00}, {32'h00000000, 2'b10},
                           {32'h00000063, 2'b10}, {32'h80000000, 2'b01}, {32'hFFFFFFFF, 2'b00},
                           {32'h23456789, 2'b00}, {32'h00010001, 2'b00}};
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int extra = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_sum = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = sent < 8;
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end
      #1;
      if (prev_stall) begin
        total++;
        if (sum !== prev_sum) $display("FAIL stall_stable: got %h want %h", sum, prev_sum);
        else pass_cnt++;
      end
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        total++;
        if ({sum, cout, ovf} !== ve[got])
          $display("FAIL b2b_beat_%0d: got %h want %h", got, {sum, cout, ovf}, ve[got]);
        else pass_cnt++;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum = sum;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    total++;
    if (got != 8) $display("FAIL b2b_count: got %0d want 8", got);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (out_valid) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL b2b_duplicate: got %0d extra results want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [33:0] r;
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(i + 1); b = 32'd1; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 total++;
    if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1 total++;
    if ({out_valid, sum} !== 33'd0) $display("FAIL mid_async_drop: got valid=%b sum=%h want 0", out_valid, sum);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL mid_stale: got %0d results want 0", seen);
    else pass_cnt++;
    run_one(32'h0000000A, 32'h00000005, 1'b0, 1'b0, r, lat);
    total++;
    if (lat != 4) $display("FAIL mid_latency: got %0d want 4", lat);
    else pass_cnt++;
    total++;
    if (r !== {32'h0000000F, 2'b00}) $display("FAIL mid_sum: got %h want %h", r, {32'h0000000F, 2'b00});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cross_chunk();
    test_limits();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
